// File: rtl/ecg_acc_pkg.sv
// Shared constants, types and helpers for the FC score collector slice.
// Contents: NUM_CLASS / SCORE_W frame geometry, counter/index widths,
//           fc_col_state_t FSM encoding, slice_lsb() packing helper.
package ecg_acc_pkg;

    localparam int unsigned NUM_CLASS = 7;
    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned CNT_W     = $clog2(NUM_CLASS);
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned FRAME_W   = NUM_CLASS * SCORE_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CLASS - 1);

    typedef logic [FRAME_W-1:0] fc_frame_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } fc_col_state_t;

    // LSB position of class k: class 0 lands in the MSB slice.
    function automatic int unsigned slice_lsb(input int unsigned k);
        return (NUM_CLASS - 1 - k) * SCORE_W;
    endfunction

endpackage

// File: rtl/fc_score_collector_if.sv
// Score-in / frame-out stream bundle for fc_score_collector.
// Signals: in_valid/in_data/in_ready (score stream, producer -> collector),
//          out_valid/out_data/out_ready (packed frame, collector -> consumer).
// Modports: slave = collector side, master = producer/consumer side.
interface fc_score_collector_if;
    import ecg_acc_pkg::*;

    logic                 in_valid;
    logic [SCORE_W-1:0]   in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    fc_frame_t            out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fc_argmax_tracker.sv
// Running signed maximum and its class index over one frame.
// Ports: clk, rst_n; clr_i (restart frame), upd_i (accepted beat),
//        idx_i (class of the beat), score_i (signed score), max_idx_o.
// Beat 0 loads unconditionally; later beats replace only on strict '>',
// so ties keep the lower index.
module fc_argmax_tracker
    import ecg_acc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               upd_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [SCORE_W-1:0] score_i,
    output logic [IDX_W-1:0]   max_idx_o
);

    logic signed [SCORE_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    // Next max/index
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (clr_i) begin
            max_d = '0;
            idx_d = '0;
        end else if (upd_i && ((idx_i == '0) || ($signed(score_i) > max_q))) begin
            max_d = $signed(score_i);
            idx_d = idx_i;
        end
    end

    // Tracker registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_idx_o = idx_q;

endmodule

// File: rtl/fc_score_collector.sv
// Collects NUM_CLASS signed scores (one per beat, class 0 first) into one
// packed frame, class 0 in the MSB slice, and holds it under valid/ready.
// Ports: clk, rst_n (async, active-low)
//        bus         fc_score_collector_if.slave (score stream in, frame out)
//        start       1-cycle pulse, opens a new frame
//        busy        FSM not in IDLE
//        frame_abort 1-cycle pulse when a partial frame is discarded by restart
//        max_idx     argmax class index (present only with FC_ARGMAX_EN)
// Build option: define FC_ARGMAX_EN to add the argmax tracker and max_idx port.
module fc_score_collector
    import ecg_acc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    fc_score_collector_if.slave   bus,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_abort
`ifdef FC_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]      max_idx
`endif
);

    fc_col_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fc_frame_t        data_q, data_d;
    logic             abort_q, abort_d;
    logic             clear_c;
    logic             accept_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start in COLLECT outranks the final beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (!start && bus.in_valid && (cnt_q == CNT_LAST)) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame clear, beat accept, abort request
    always_comb begin
        clear_c  = 1'b0;
        accept_c = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear_c = start;
            end
            COLLECT: begin
                clear_c  = start;
                abort_d  = start && (cnt_q != '0);
                accept_c = !start && bus.in_valid;
            end
            default: ;
        endcase
    end

    // Slice write and beat counter; counter saturates at the last class
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_c) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (accept_c) begin
            data_d[slice_lsb(32'(cnt_q)) +: SCORE_W] = bus.in_data;
            if (cnt_q != CNT_LAST) begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            abort_q <= abort_d;
        end
    end

    // Outputs are decodes of registered state
    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign busy          = (state_q != IDLE);
    assign frame_abort   = abort_q;

`ifdef FC_ARGMAX_EN
    fc_argmax_tracker u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clear_c),
        .upd_i     (accept_c),
        .idx_i     (IDX_W'(cnt_q)),
        .score_i   (bus.in_data),
        .max_idx_o (max_idx)
    );
`endif

endmodule

// File: tb/tb_fc_score_collector.sv
// Scoreboard bench for fc_score_collector: stimulus pushes expected frames,
// a negedge monitor pops and compares on every out_valid & out_ready.
module tb_fc_score_collector;
    import ecg_acc_pkg::*;

    localparam int unsigned OW = FRAME_W;

    typedef struct {
        logic [OW-1:0]    data;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic frame_abort;
`ifdef FC_ARGMAX_EN
    logic [IDX_W-1:0] max_idx;
`endif

    fc_score_collector_if bus ();

    fc_score_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .start       (start),
        .busy        (busy),
        .frame_abort (frame_abort)
`ifdef FC_ARGMAX_EN
        ,
        .max_idx     (max_idx)
`endif
    );

    int   total;
    int   bad;
    int   aborts;
    exp_t q [$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Class k at [(NUM_CLASS-k)*SCORE_W-1 -: SCORE_W]
    function automatic logic [OW-1:0] pack(input int v [NUM_CLASS]);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NUM_CLASS); k++) begin
            r[(int'(NUM_CLASS) - k) * int'(SCORE_W) - 1 -: SCORE_W] = SCORE_W'(v[k]);
        end
        return r;
    endfunction

    // Monitor: abort pulses and frame handshakes
    always @(negedge clk) begin
        if (rst_n && frame_abort) aborts++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got %h want none", bus.out_data);
            end else begin
                mon_e = q.pop_front();
                chkw("frame_data", bus.out_data, mon_e.data);
`ifdef FC_ARGMAX_EN
                chkw("frame_max_idx", OW'(max_idx), OW'(mon_e.idx));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = SCORE_W'(v);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int v [NUM_CLASS], input bit bubbles);
        for (int k = 0; k < int'(NUM_CLASS); k++) begin
            beat(v[k]);
            if (bubbles && k < int'(NUM_CLASS) - 1) tick();
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1("idle_after_ready", busy, 1'b0);
        chk1("valid_drop", bus.out_valid, 1'b0);
    endtask

    initial begin
        int v [NUM_CLASS];
        int ab0;
        logic [OW-1:0] keep;

        total = 0;
        bad = 0;
        aborts = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_abort", frame_abort, 1'b0);
        chkw("rst_out_data", bus.out_data, '0);
`ifdef FC_ARGMAX_EN
        chkw("rst_max_idx", OW'(max_idx), '0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: normal frame, latency 1 cycle after final beat
        v = '{5, -3, 100, 7, -512, 511, 0};
        q.push_back('{data: pack(v), idx: IDX_W'(5)});
        pulse_start();
        chk1("t1_in_ready", bus.in_ready, 1'b1);
        for (int k = 0; k < int'(NUM_CLASS) - 1; k++) beat(v[k]);
        chk1("t1_no_early_valid", bus.out_valid, 1'b0);
        beat(v[NUM_CLASS-1]);
        chk1("t1_valid_latency", bus.out_valid, 1'b1);
        chk1("t1_in_ready_hold", bus.in_ready, 1'b0);
        handshake();

        // 2: bubbles and 10 cycles of backpressure
        q.push_back('{data: pack(v), idx: IDX_W'(5)});
        pulse_start();
        send_frame(v, 1'b1);
        for (int c = 0; c < 10; c++) begin
            chk1("t2_valid_held", bus.out_valid, 1'b1);
            chkw("t2_data_stable", bus.out_data, pack(v));
            tick();
        end
        handshake();

        // 3: abort after 3 beats, then 7 beats of 9
        ab0 = aborts;
        v = '{9, 9, 9, 9, 9, 9, 9};
        q.push_back('{data: pack(v), idx: IDX_W'(0)});
        pulse_start();
        beat(1);
        beat(2);
        beat(3);
        pulse_start();
        send_frame(v, 1'b0);
        chk1("t3_one_abort", aborts == ab0 + 1, 1'b1);
        handshake();

        // 4: silent restart at cnt==0, all scores -1
        ab0 = aborts;
        v = '{-1, -1, -1, -1, -1, -1, -1};
        q.push_back('{data: 70'h3F_FFFF_FFFF_FFFF_FFFF, idx: IDX_W'(0)});
        pulse_start();
        pulse_start();
        send_frame(v, 1'b0);
        chkw("t4_all_ones", bus.out_data, 70'h3F_FFFF_FFFF_FFFF_FFFF);
        chk1("t4_no_abort", aborts == ab0, 1'b1);
        handshake();

        // start together with the final beat aborts the frame
        ab0 = aborts;
        pulse_start();
        for (int k = 0; k < int'(NUM_CLASS) - 1; k++) beat(4);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = SCORE_W'(50);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk1("tf_still_collect", bus.out_valid, 1'b0);
        chkw("tf_cleared", bus.out_data, '0);
        v = '{-7, 20, -30, 40, 511, 60, -512};
        q.push_back('{data: pack(v), idx: IDX_W'(4)});
        send_frame(v, 1'b0);
        chk1("tf_abort", aborts == ab0 + 1, 1'b1);
        handshake();

        // 5: async reset after 4 beats
        pulse_start();
        for (int k = 0; k < 4; k++) beat(100 + k);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_in_ready", bus.in_ready, 1'b0);
        chk1("t5_out_valid", bus.out_valid, 1'b0);
        chk1("t5_abort", frame_abort, 1'b0);
        chkw("t5_out_data", bus.out_data, '0);
`ifdef FC_ARGMAX_EN
        chkw("t5_max_idx", OW'(max_idx), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        v = '{10, -20, 30, -40, 50, -60, 70};
        q.push_back('{data: pack(v), idx: IDX_W'(6)});
        pulse_start();
        send_frame(v, 1'b0);
        handshake();
        keep = pack(v);

        // 6: in_valid in IDLE is ignored
        bus.in_valid = 1'b1;
        bus.in_data = SCORE_W'(123);
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk1("t6_idle_busy", busy, 1'b0);
        chk1("t6_idle_in_ready", bus.in_ready, 1'b0);
        chkw("t6_idle_data", bus.out_data, keep);

        // 6: start in HOLD ignored, start lost with out_ready
        ab0 = aborts;
        v = '{8, 1, 2, 3, 4, 5, 6};
        q.push_back('{data: pack(v), idx: IDX_W'(0)});
        pulse_start();
        send_frame(v, 1'b0);
        pulse_start();
        chk1("t6_hold_busy", busy, 1'b1);
        chk1("t6_hold_valid", bus.out_valid, 1'b1);
        chkw("t6_hold_data", bus.out_data, pack(v));
        start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        bus.out_ready = 1'b0;
        chk1("t6_start_lost", busy, 1'b0);
        tick();
        chk1("t6_still_idle", busy, 1'b0);
        chk1("t6_no_abort", aborts == ab0, 1'b1);

        tick();
        chkw("queue_empty", OW'(q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
